// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - buffered MIPS-54 decode stage: {instr,pc} FIFO feeding a registered decode bundle
// Optional DECODE_STATS_EN adds stat_decoded/stat_illegal handshake counters.
module decode_stage #(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 32,
  parameter int FLAG_W = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr_in,
  input  logic [PC_W-1:0]   pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLAG_W-1:0] op_flags,
  output logic              illegal,
  output logic [4:0]        rs_c,
  output logic [4:0]        rt_c,
  output logic [4:0]        rd_c,
  output logic [4:0]        shamt,
  output logic [15:0]       immediate,
  output logic [25:0]       address,
  output logic [PC_W-1:0]   pc_out
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]       stat_decoded,
  output logic [31:0]       stat_illegal
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam int OP_ADD = 0, OP_ADDU = 1, OP_SUB = 2, OP_SUBU = 3, OP_AND = 4, OP_OR = 5;
  localparam int OP_XOR = 6, OP_NOR = 7, OP_SLT = 8, OP_SLTU = 9, OP_SLL = 10, OP_SRL = 11;
  localparam int OP_SRA = 12, OP_SLLV = 13, OP_SRLV = 14, OP_SRAV = 15, OP_JR = 16;
  localparam int OP_ADDI = 17, OP_ADDIU = 18, OP_ANDI = 19, OP_ORI = 20, OP_XORI = 21;
  localparam int OP_LW = 22, OP_SW = 23, OP_BEQ = 24, OP_BNE = 25, OP_SLTI = 26, OP_SLTIU = 27;
  localparam int OP_LUI = 28, OP_J = 29, OP_JAL = 30, OP_CLZ = 31, OP_DIVU = 32, OP_DIV = 33;
  localparam int OP_MULTU = 34, OP_MUL = 35, OP_JALR = 36, OP_LB = 37, OP_LBU = 38, OP_LH = 39;
  localparam int OP_LHU = 40, OP_SB = 41, OP_SH = 42, OP_ERET = 43, OP_MFHI = 44, OP_MFLO = 45;
  localparam int OP_MTHI = 46, OP_MTLO = 47, OP_MTC0 = 48, OP_MFC0 = 49, OP_SYSCALL = 50;
  localparam int OP_TEQ = 51, OP_BREAK = 52, OP_BGEZ = 53;

  logic [31:0]       r_mem_instr [DEPTH];
  logic [PC_W-1:0]   r_mem_pc    [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [FLAG_W-1:0] r_flags;
  logic              r_illegal;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [4:0]        r_shamt;
  logic [15:0]       r_imm;
  logic [25:0]       r_addr;
  logic [PC_W-1:0]   r_pc;

  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count_nxt;
  logic [31:0]       w_head;
  logic [PC_W-1:0]   w_head_pc;
  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs_f;
  logic [4:0]        w_rt_f;
  logic              w_special;
  logic              w_special2;
  logic              w_cop0;
  logic [FLAG_W-1:0] w_flags;
  logic              w_reads_rs;
  logic              w_reads_rt;
  logic              w_rd_r;
  logic              w_rd_i;
  logic              w_imm;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;

  // Ready is registered, so a pop in the same cycle never reopens a full FIFO early.
  assign w_push      = in_valid && r_in_ready && !flush && !rst;
  assign w_pop       = (r_count != '0) && (!r_out_valid || out_ready) && !flush && !rst;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign w_head     = r_mem_instr[r_rd_ptr];
  assign w_head_pc  = r_mem_pc[r_rd_ptr];
  assign w_op       = w_head[31:26];
  assign w_funct    = w_head[5:0];
  assign w_rs_f     = w_head[25:21];
  assign w_rt_f     = w_head[20:16];
  assign w_special  = (w_op == 6'b000000);
  assign w_special2 = (w_op == 6'b011100);
  assign w_cop0     = (w_op == 6'b010000);

  always_comb begin
    w_flags = '0;
    w_flags[OP_ADD]     = w_special && (w_funct == 6'b100000);
    w_flags[OP_ADDU]    = w_special && (w_funct == 6'b100001);
    w_flags[OP_SUB]     = w_special && (w_funct == 6'b100010);
    w_flags[OP_SUBU]    = w_special && (w_funct == 6'b100011);
    w_flags[OP_AND]     = w_special && (w_funct == 6'b100100);
    w_flags[OP_OR]      = w_special && (w_funct == 6'b100101);
    w_flags[OP_XOR]     = w_special && (w_funct == 6'b100110);
    w_flags[OP_NOR]     = w_special && (w_funct == 6'b100111);
    w_flags[OP_SLT]     = w_special && (w_funct == 6'b101010);
    w_flags[OP_SLTU]    = w_special && (w_funct == 6'b101011);
    w_flags[OP_SLL]     = w_special && (w_funct == 6'b000000);
    w_flags[OP_SRL]     = w_special && (w_funct == 6'b000010);
    w_flags[OP_SRA]     = w_special && (w_funct == 6'b000011);
    w_flags[OP_SLLV]    = w_special && (w_funct == 6'b000100);
    w_flags[OP_SRLV]    = w_special && (w_funct == 6'b000110);
    w_flags[OP_SRAV]    = w_special && (w_funct == 6'b000111);
    w_flags[OP_JR]      = w_special && (w_funct == 6'b001000);
    w_flags[OP_ADDI]    = (w_op == 6'b001000);
    w_flags[OP_ADDIU]   = (w_op == 6'b001001);
    w_flags[OP_ANDI]    = (w_op == 6'b001100);
    w_flags[OP_ORI]     = (w_op == 6'b001101);
    w_flags[OP_XORI]    = (w_op == 6'b001110);
    w_flags[OP_LW]      = (w_op == 6'b100011);
    w_flags[OP_SW]      = (w_op == 6'b101011);
    w_flags[OP_BEQ]     = (w_op == 6'b000100);
    w_flags[OP_BNE]     = (w_op == 6'b000101);
    w_flags[OP_SLTI]    = (w_op == 6'b001010);
    w_flags[OP_SLTIU]   = (w_op == 6'b001011);
    w_flags[OP_LUI]     = (w_op == 6'b001111);
    w_flags[OP_J]       = (w_op == 6'b000010);
    w_flags[OP_JAL]     = (w_op == 6'b000011);
    w_flags[OP_CLZ]     = w_special2 && (w_funct == 6'b100000);
    w_flags[OP_DIVU]    = w_special && (w_funct == 6'b011011);
    w_flags[OP_DIV]     = w_special && (w_funct == 6'b011010);
    w_flags[OP_MULTU]   = w_special && (w_funct == 6'b011001);
    w_flags[OP_MUL]     = w_special2 && (w_funct == 6'b000010);
    w_flags[OP_JALR]    = w_special && (w_funct == 6'b001001);
    w_flags[OP_LB]      = (w_op == 6'b100000);
    w_flags[OP_LBU]     = (w_op == 6'b100100);
    w_flags[OP_LH]      = (w_op == 6'b100001);
    w_flags[OP_LHU]     = (w_op == 6'b100101);
    w_flags[OP_SB]      = (w_op == 6'b101000);
    w_flags[OP_SH]      = (w_op == 6'b101001);
    w_flags[OP_ERET]    = w_cop0 && (w_funct == 6'b011000);
    w_flags[OP_MFHI]    = w_special && (w_funct == 6'b010000);
    w_flags[OP_MFLO]    = w_special && (w_funct == 6'b010010);
    w_flags[OP_MTHI]    = w_special && (w_funct == 6'b010001);
    w_flags[OP_MTLO]    = w_special && (w_funct == 6'b010011);
    w_flags[OP_MTC0]    = w_cop0 && (w_funct == 6'b000000) && (w_rs_f == 5'b00100);
    w_flags[OP_MFC0]    = w_cop0 && (w_funct == 6'b000000) && (w_rs_f == 5'b00000);
    w_flags[OP_SYSCALL] = w_special && (w_funct == 6'b001100);
    w_flags[OP_TEQ]     = w_special && (w_funct == 6'b110100);
    w_flags[OP_BREAK]   = w_special && (w_funct == 6'b001101);
    w_flags[OP_BGEZ]    = (w_op == 6'b000001) && (w_rt_f == 5'b00001);
  end

  // Operand-usage classes; the index ranges lean on the contiguous op numbering above.
  assign w_reads_rs = |w_flags[OP_SLTU:OP_ADD] | |w_flags[OP_SLTIU:OP_SLLV] | |w_flags[OP_SH:OP_CLZ]
                    | w_flags[OP_MTHI] | w_flags[OP_MTLO] | w_flags[OP_TEQ] | w_flags[OP_BGEZ];
  assign w_reads_rt = |w_flags[OP_SRAV:OP_ADD] | |w_flags[OP_BNE:OP_SW] | |w_flags[OP_MUL:OP_DIVU]
                    | w_flags[OP_SB] | w_flags[OP_SH] | w_flags[OP_MTC0] | w_flags[OP_TEQ];
  assign w_rd_r     = |w_flags[OP_SRAV:OP_ADD] | w_flags[OP_CLZ] | w_flags[OP_MUL] | w_flags[OP_JALR]
                    | w_flags[OP_MFHI] | w_flags[OP_MFLO];
  assign w_rd_i     = |w_flags[OP_LW:OP_ADDI] | |w_flags[OP_LUI:OP_SLTI] | |w_flags[OP_LHU:OP_LB]
                    | w_flags[OP_MFC0];
  assign w_imm      = |w_flags[OP_LUI:OP_ADDI] | |w_flags[OP_SH:OP_LB] | w_flags[OP_BGEZ];

  always_comb begin
    w_rs = 5'd0;
    w_rt = 5'd0;
    w_rd = 5'd0;
    if (w_flags[OP_MTC0])  w_rs = w_head[15:11];
    else if (w_reads_rs)   w_rs = w_head[25:21];
    if (w_flags[OP_MFC0])  w_rt = w_head[15:11];
    else if (w_reads_rt)   w_rt = w_head[20:16];
    if (w_flags[OP_JAL])   w_rd = 5'd31;
    else if (w_rd_r)       w_rd = w_head[15:11];
    else if (w_rd_i)       w_rd = w_head[20:16];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= instr_in;
      r_mem_pc[r_wr_ptr]    <= pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= !rst;
      r_out_valid <= 1'b0;
      r_flags     <= '0;
      r_illegal   <= 1'b0;
      r_rs        <= 5'd0;
      r_rt        <= 5'd0;
      r_rd        <= 5'd0;
      r_shamt     <= 5'd0;
      r_imm       <= 16'd0;
      r_addr      <= 26'd0;
      r_pc        <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_out_valid <= 1'b1;
        r_flags     <= w_flags;
        r_illegal   <= ~|w_flags;
        r_rs        <= w_rs;
        r_rt        <= w_rt;
        r_rd        <= w_rd;
        r_shamt     <= (|w_flags[OP_SRA:OP_SLL]) ? w_head[10:6] : 5'd0;
        r_imm       <= w_imm ? w_head[15:0] : 16'd0;
        r_addr      <= (w_flags[OP_J] | w_flags[OP_JAL]) ? w_head[25:0] : 26'd0;
        r_pc        <= w_head_pc;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (r_count != '0)) assert ($onehot0(w_flags));
  end

`ifdef DECODE_STATS_EN
  logic [31:0] r_stat_decoded;
  logic [31:0] r_stat_illegal;

  // Counters survive flush so software sees totals across redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_decoded <= 32'd0;
      r_stat_illegal <= 32'd0;
    end else if (r_out_valid && out_ready) begin
      r_stat_decoded <= r_stat_decoded + 32'd1;
      if (r_illegal) r_stat_illegal <= r_stat_illegal + 32'd1;
    end
  end

  assign stat_decoded = r_stat_decoded;
  assign stat_illegal = r_stat_illegal;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign op_flags  = r_flags;
  assign illegal   = r_illegal;
  assign rs_c      = r_rs;
  assign rt_c      = r_rt;
  assign rd_c      = r_rd;
  assign shamt     = r_shamt;
  assign immediate = r_imm;
  assign address   = r_addr;
  assign pc_out    = r_pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized bench for decode_stage against a table-driven reference model
module tb_decode_stage;
  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int FLAG_W = 54;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0]       instr_in;
  logic [PC_W-1:0]   pc_in, pc_out;
  logic [FLAG_W-1:0] op_flags;
  logic [4:0]        rs_c, rt_c, rd_c, shamt;
  logic [15:0]       immediate;
  logic [25:0]       address;
`ifdef DECODE_STATS_EN
  logic [31:0]       stat_decoded, stat_illegal;
`endif

  decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
    .op_flags(op_flags), .illegal(illegal), .rs_c(rs_c), .rt_c(rt_c), .rd_c(rd_c),
    .shamt(shamt), .immediate(immediate), .address(address), .pc_out(pc_out)
`ifdef DECODE_STATS_EN
    , .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
`endif
  );

  // One row per op: encoding match (-1 = don't care) and where each field comes from.
  typedef struct {int op; int fn; int rsc; int rtc; int rs_s; int rt_s; int rd_s; int imm; int adr; int sh;} ent_t;
  ent_t tbl [54];

  typedef struct packed {
    logic [53:0] flags; logic ill; logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic [4:0] sh;
    logic [15:0] imm; logic [25:0] adr; logic [31:0] pc;
  } bun_t;

  int checks = 0;
  int errors = 0;
  logic [63:0] q [$];
  bit          m_ready, m_ov;
  bun_t        m_b, mb;
  int unsigned m_sd, m_si;

  task automatic d(input int i, input int op, input int fn, input int rsc, input int rtc,
                   input int rs_s, input int rt_s, input int rd_s, input int imm, input int adr, input int sh);
    tbl[i] = '{op, fn, rsc, rtc, rs_s, rt_s, rd_s, imm, adr, sh};
  endtask

  task automatic build_table();
    int fa [10];
    fa = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
    for (int i = 0; i < 10; i++) d(i, 0, fa[i], -1, -1, 1, 1, 1, 0, 0, 0);
    d(10, 0, 0, -1, -1, 0, 1, 1, 0, 0, 1);  d(11, 0, 2, -1, -1, 0, 1, 1, 0, 0, 1);
    d(12, 0, 3, -1, -1, 0, 1, 1, 0, 0, 1);  d(13, 0, 4, -1, -1, 1, 1, 1, 0, 0, 0);
    d(14, 0, 6, -1, -1, 1, 1, 1, 0, 0, 0);  d(15, 0, 7, -1, -1, 1, 1, 1, 0, 0, 0);
    d(16, 0, 8, -1, -1, 1, 0, 0, 0, 0, 0);  d(17, 8, -1, -1, -1, 1, 0, 2, 1, 0, 0);
    d(18, 9, -1, -1, -1, 1, 0, 2, 1, 0, 0); d(19, 12, -1, -1, -1, 1, 0, 2, 1, 0, 0);
    d(20, 13, -1, -1, -1, 1, 0, 2, 1, 0, 0); d(21, 14, -1, -1, -1, 1, 0, 2, 1, 0, 0);
    d(22, 35, -1, -1, -1, 1, 0, 2, 1, 0, 0); d(23, 43, -1, -1, -1, 1, 1, 0, 1, 0, 0);
    d(24, 4, -1, -1, -1, 1, 1, 0, 1, 0, 0); d(25, 5, -1, -1, -1, 1, 1, 0, 1, 0, 0);
    d(26, 10, -1, -1, -1, 1, 0, 2, 1, 0, 0); d(27, 11, -1, -1, -1, 1, 0, 2, 1, 0, 0);
    d(28, 15, -1, -1, -1, 0, 0, 2, 1, 0, 0); d(29, 2, -1, -1, -1, 0, 0, 0, 0, 1, 0);
    d(30, 3, -1, -1, -1, 0, 0, 3, 0, 1, 0); d(31, 28, 32, -1, -1, 1, 0, 1, 0, 0, 0);
    d(32, 0, 27, -1, -1, 1, 1, 0, 0, 0, 0); d(33, 0, 26, -1, -1, 1, 1, 0, 0, 0, 0);
    d(34, 0, 25, -1, -1, 1, 1, 0, 0, 0, 0); d(35, 28, 2, -1, -1, 1, 1, 1, 0, 0, 0);
    d(36, 0, 9, -1, -1, 1, 0, 1, 0, 0, 0);  d(37, 32, -1, -1, -1, 1, 0, 2, 1, 0, 0);
    d(38, 36, -1, -1, -1, 1, 0, 2, 1, 0, 0); d(39, 33, -1, -1, -1, 1, 0, 2, 1, 0, 0);
    d(40, 37, -1, -1, -1, 1, 0, 2, 1, 0, 0); d(41, 40, -1, -1, -1, 1, 1, 0, 1, 0, 0);
    d(42, 41, -1, -1, -1, 1, 1, 0, 1, 0, 0); d(43, 16, 24, -1, -1, 0, 0, 0, 0, 0, 0);
    d(44, 0, 16, -1, -1, 0, 0, 1, 0, 0, 0); d(45, 0, 18, -1, -1, 0, 0, 1, 0, 0, 0);
    d(46, 0, 17, -1, -1, 1, 0, 0, 0, 0, 0); d(47, 0, 19, -1, -1, 1, 0, 0, 0, 0, 0);
    d(48, 16, 0, 4, -1, 2, 1, 0, 0, 0, 0);  d(49, 16, 0, 0, -1, 0, 2, 2, 0, 0, 0);
    d(50, 0, 12, -1, -1, 0, 0, 0, 0, 0, 0); d(51, 0, 52, -1, -1, 1, 1, 0, 0, 0, 0);
    d(52, 0, 13, -1, -1, 0, 0, 0, 0, 0, 0); d(53, 1, -1, -1, 1, 1, 0, 0, 1, 0, 0);
  endtask

  function automatic bun_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    bun_t b;
    int hit;
    b = '0;
    b.pc = pc;
    hit = -1;
    for (int i = 0; i < 54; i++)
      if (hit < 0 && int'(w[31:26]) == tbl[i].op && (tbl[i].fn < 0 || int'(w[5:0]) == tbl[i].fn)
          && (tbl[i].rsc < 0 || int'(w[25:21]) == tbl[i].rsc) && (tbl[i].rtc < 0 || int'(w[20:16]) == tbl[i].rtc))
        hit = i;
    if (hit < 0) begin
      b.ill = 1'b1;
      return b;
    end
    b.flags[hit] = 1'b1;
    if (tbl[hit].rs_s == 1) b.rs = w[25:21];
    if (tbl[hit].rs_s == 2) b.rs = w[15:11];
    if (tbl[hit].rt_s == 1) b.rt = w[20:16];
    if (tbl[hit].rt_s == 2) b.rt = w[15:11];
    if (tbl[hit].rd_s == 1) b.rd = w[15:11];
    if (tbl[hit].rd_s == 2) b.rd = w[20:16];
    if (tbl[hit].rd_s == 3) b.rd = 5'd31;
    if (tbl[hit].imm != 0) b.imm = w[15:0];
    if (tbl[hit].adr != 0) b.adr = w[25:0];
    if (tbl[hit].sh != 0)  b.sh = w[10:6];
    return b;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int i;
    w = $urandom;
    if ($urandom_range(0, 7) == 0) return w;
    i = $urandom_range(0, 53);
    w[31:26] = 6'(tbl[i].op);
    if (tbl[i].fn >= 0)  w[5:0]   = 6'(tbl[i].fn);
    if (tbl[i].rsc >= 0) w[25:21] = 5'(tbl[i].rsc);
    if (tbl[i].rtc >= 0) w[20:16] = 5'(tbl[i].rtc);
    return w;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic compare();
    check("in_ready", 64'(in_ready), 64'(m_ready));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("op_flags", 64'(op_flags), 64'(m_b.flags));
    check("illegal", 64'(illegal), 64'(m_b.ill));
    check("rs_c", 64'(rs_c), 64'(m_b.rs));
    check("rt_c", 64'(rt_c), 64'(m_b.rt));
    check("rd_c", 64'(rd_c), 64'(m_b.rd));
    check("shamt", 64'(shamt), 64'(m_b.sh));
    check("immediate", 64'(immediate), 64'(m_b.imm));
    check("address", 64'(address), 64'(m_b.adr));
    check("pc_out", 64'(pc_out), 64'(m_b.pc));
`ifdef DECODE_STATS_EN
    check("stat_decoded", 64'(stat_decoded), 64'(m_sd));
    check("stat_illegal", 64'(stat_illegal), 64'(m_si));
`endif
  endtask

  // Drive one cycle, advance the reference model, then check after the edge.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl, input bit rs);
    bit push, pop;
    logic [63:0] e;
    in_valid = iv; instr_in = ins; pc_in = pc; out_ready = ordy; flush = fl; rst = rs;
    if (rs) begin
      q.delete(); m_ready = 0; m_ov = 0; m_b = '0; m_sd = 0; m_si = 0;
    end else begin
      push = iv && m_ready;
      pop  = (q.size() != 0) && (!m_ov || ordy);
      if (m_ov && ordy) begin
        m_sd++;
        if (m_b.ill) m_si++;
      end
      if (fl) begin
        q.delete(); m_ov = 0; m_b = '0; m_ready = 1;
      end else begin
        if (pop) begin
          e = q.pop_front();
          m_b = ref_decode(e[63:32], e[31:0]);
          m_ov = 1;
        end else if (ordy) begin
          m_ov = 0;
        end
        if (push) q.push_back({ins, pc});
        m_ready = (q.size() != DEPTH);
      end
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    build_table();
    mb = ref_decode(32'h00221820, 32'h0);
    check("model_add", 64'({mb.flags, mb.rs, mb.rt, mb.rd}), {10'd0, 54'h1} << 15 | 64'h0443);
    mb = ref_decode(32'h40856000, 32'h0);
    check("model_mtc0", 64'({mb.flags, mb.rs, mb.rt}), ({10'd0, 54'h1} << 58) | 64'h0185);

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_flags", 64'(op_flags), 64'h0);
    idle(1);
    check("post_rst_ready", 64'(in_ready), 64'h1);

    step(1, 32'h00221820, 32'h100, 1, 0, 0);
    check("add_latency", 64'(out_valid), 64'h0);
    idle(1);
    check("add_valid", 64'(out_valid), 64'h1);
    check("add_flags", 64'(op_flags), 64'h1);
    check("add_regs", 64'({rs_c, rt_c, rd_c, immediate}), {33'd0, 5'd1, 5'd2, 5'd3, 16'd0});

    step(1, 32'h0C000010, 32'h400, 1, 0, 0);
    idle(1);
    check("jal_flags", 64'(op_flags), 64'h1 << 30);
    check("jal_rd", 64'(rd_c), 64'd31);
    check("jal_addr_pc", {6'd0, address, pc_out}, 64'h0000_0010_0000_0400);

    step(1, 32'hFC000000, 32'h404, 1, 0, 0);
    idle(1);
    check("ill_bits", 64'({out_valid, illegal, op_flags}), {8'd0, 2'b11, 54'd0});

    step(1, 32'h40856000, 32'h408, 1, 0, 0);
    idle(1);
    check("mtc0_flags", 64'(op_flags), 64'h1 << 48);
    check("mtc0_regs", 64'({rt_c, rs_c}), 64'h0AC);
    idle(1);

    for (int k = 0; k < 4; k++) begin
      step(1, 32'h00221821 + 32'(k), 32'h1000 + 32'(4 * k), 0, 0, 0);
      if (k == 2) check("full_ready", 64'(in_ready), 64'h0);
    end
    check("stall_pc", 64'(pc_out), 64'h1000);
    idle(1);
    check("drain_pc1", 64'(pc_out), 64'h1004);
    idle(1);
    check("drain_pc2", 64'(pc_out), 64'h1008);
    idle(1);
    check("drain_empty", 64'(out_valid), 64'h0);

    step(1, 32'h00221820, 32'h2000, 0, 0, 0);
    step(1, 32'h00221822, 32'h2004, 0, 0, 0);
    step(1, 32'h00221824, 32'h2008, 0, 0, 0);
    step(1, 32'h00221826, 32'h200C, 0, 1, 0);
    check("flush_valid", 64'({out_valid, in_ready}), 64'h1);
    idle(1);
    check("flush_lost", 64'(out_valid), 64'h0);

    step(1, 32'h00221820, 32'h3000, 1, 0, 0);
    idle(1);
    step(1, 32'h00221822, 32'h3004, 1, 0, 1);
    check("midrst_out", 64'({out_valid, in_ready, rs_c, rt_c, rd_c}), 64'h0);
    check("midrst_bundle", 64'(op_flags) | 64'(pc_out), 64'h0);

    for (int n = 0; n < 4000; n++)
      step($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 499) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
